// File: rtl/lu_vector_seq.sv
// Stimulus sequencer and result collector for the two-function logic unit.
// Sweeps {ch,a,b} through all eight combinations, captures the unit's OR and
// AND outputs into two truth tables and flags any deviation from the expected
// tables. Each vector is held for HOLD cycles and then sampled for one cycle.
module lu_vector_seq #(
  parameter int unsigned HOLD    = 1,        // legal range 1..15
  parameter logic [3:0]  EXP_OR  = 4'b1110,  // indexed by {a,b}
  parameter logic [3:0]  EXP_AND = 4'b1000   // indexed by {a,b}
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_or,
  input  logic       s_and,
  output logic       a,
  output logic       b,
  output logic       ch,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_or,
  output logic [3:0] table_and,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;          // {ch,a,b} of the vector being driven
  logic [3:0] hold_q, hold_d;        // remaining DRIVE cycles before SAMPLE
  logic [3:0] table_or_q, table_or_d;
  logic [3:0] table_and_q, table_and_d;
  logic       mismatch_q, mismatch_d;
  logic [1:0] ab;                    // table index {a,b} of the current vector

  assign ab = idx_q[1:0];

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      hold_q      <= 4'd0;
      table_or_q  <= 4'b0000;
      table_and_q <= 4'b0000;
      mismatch_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      table_or_q  <= table_or_d;
      table_and_q <= table_and_d;
      mismatch_q  <= mismatch_d;
    end
  end

  // Next-state logic: sequencing, table capture and mismatch detection.
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    table_or_d  = table_or_q;
    table_and_d = table_and_q;
    mismatch_d  = mismatch_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          table_or_d  = 4'b0000;
          table_and_d = 4'b0000;
          mismatch_d  = 1'b0;
          idx_d       = 3'd0;
          hold_d      = HOLD_RELOAD;
          state_d     = DRIVE;
        end
      end

      DRIVE: begin
        if (hold_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end

      SAMPLE: begin
        if (!idx_q[2]) begin
          // OR function selected: the AND path must stay quiet.
          table_or_d[ab] = s_or;
          if ((s_or != EXP_OR[ab]) || s_and) begin
            mismatch_d = 1'b1;
          end
        end else begin
          // AND function selected: the OR path must stay quiet.
          table_and_d[ab] = s_and;
          if ((s_and != EXP_AND[ab]) || s_or) begin
            mismatch_d = 1'b1;
          end
        end
        // After the last vector idx wraps to 0, which returns a/b/ch to 0
        // for FINISH and IDLE without a separate clear.
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = FINISH;
        end else begin
          hold_d  = HOLD_RELOAD;
          state_d = DRIVE;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands come straight from the idx register; status decodes the state.
  assign b         = idx_q[0];
  assign a         = idx_q[1];
  assign ch        = idx_q[2];
  assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done      = (state_q == FINISH);
  assign table_or  = table_or_q;
  assign table_and = table_and_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_lu_vector_seq.sv
// Bench for lu_vector_seq: two instances (HOLD = 1 and HOLD = 3), each in
// front of a behavioural logic-unit model with selectable faults. Expected
// sweep results are pushed to a scoreboard at start and popped on done; a
// per-cycle monitor checks the vector sequence, busy and done timing.
module tb_lu_vector_seq;

  localparam logic [3:0] GOLD_OR  = 4'b1110;
  localparam logic [3:0] GOLD_AND = 4'b1000;

  // Logic-unit model modes.
  localparam int LU_GOOD  = 0;
  localparam int LU_OR0   = 1;  // s_or stuck at 0
  localparam int LU_AND1  = 2;  // s_and stuck at 1

  typedef struct packed {
    logic [3:0] tor;
    logic [3:0] tand;
    logic       mm;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       start1, sor1, sand1, a1, b1, ch1, busy1, done1, mm1;
  logic [3:0] tor1, tand1;
  logic       start3, sor3, sand3, a3, b3, ch3, busy3, done3, mm3;
  logic [3:0] tor3, tand3;

  int   mode [2];
  int   e0 [2];
  bit   active [2];
  exp_t sb0 [$];
  exp_t sb1 [$];
  int   cyc;
  int   n_checks;
  int   n_errors;

  function automatic logic lu_or(input int m, input logic c, input logic x, input logic y);
    if (m == LU_OR0) return 1'b0;
    return c ? 1'b0 : (x | y);
  endfunction

  function automatic logic lu_and(input int m, input logic c, input logic x, input logic y);
    if (m == LU_AND1) return 1'b1;
    return c ? (x & y) : 1'b0;
  endfunction

  // Expected sweep outcome for a given logic-unit model.
  function automatic exp_t sweep_model(input int m);
    exp_t       e;
    logic [2:0] v;
    logic       lo, la;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      v  = 3'(k);
      lo = lu_or(m, v[2], v[1], v[0]);
      la = lu_and(m, v[2], v[1], v[0]);
      if (!v[2]) begin
        e.tor[v[1:0]] = lo;
        if (lo != GOLD_OR[v[1:0]] || la) e.mm = 1'b1;
      end else begin
        e.tand[v[1:0]] = la;
        if (la != GOLD_AND[v[1:0]] || lo) e.mm = 1'b1;
      end
    end
    return e;
  endfunction

  assign sor1  = lu_or(mode[0], ch1, a1, b1);
  assign sand1 = lu_and(mode[0], ch1, a1, b1);
  assign sor3  = lu_or(mode[1], ch3, a3, b3);
  assign sand3 = lu_and(mode[1], ch3, a3, b3);

  lu_vector_seq #(.HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s_or(sor1), .s_and(sand1),
    .a(a1), .b(b1), .ch(ch1), .busy(busy1), .done(done1),
    .table_or(tor1), .table_and(tand1), .mismatch(mm1)
  );

  lu_vector_seq #(.HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .s_or(sor3), .s_and(sand3),
    .a(a3), .b(b3), .ch(ch3), .busy(busy3), .done(done3),
    .table_or(tor3), .table_and(tand3), .mismatch(mm3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle of monitoring for instance id with hold h.
  task automatic monitor(input int id, input int h, input logic [2:0] vec,
                         input logic bsy, input logic dn, input logic [3:0] tor,
                         input logic [3:0] tand, input logic mm);
    int   n, len;
    exp_t e;
    len = 8 * (h + 1);
    if (!active[id]) begin
      check($sformatf("d%0d_idle_busy", id), bsy, 0);
      check($sformatf("d%0d_idle_done", id), dn, 0);
      check($sformatf("d%0d_idle_vec", id), vec, 0);
    end else begin
      n = cyc - e0[id];
      if (n < len) begin
        check($sformatf("d%0d_vec_n%0d", id, n), vec, 32'(n / (h + 1)));
        check($sformatf("d%0d_busy_n%0d", id, n), bsy, 1);
        check($sformatf("d%0d_done_n%0d", id, n), dn, 0);
        if (n == 0) begin
          check($sformatf("d%0d_clr_or", id), tor, 0);
          check($sformatf("d%0d_clr_and", id), tand, 0);
          check($sformatf("d%0d_clr_mm", id), mm, 0);
        end
      end else begin
        check($sformatf("d%0d_done_pulse", id), dn, 1);
        check($sformatf("d%0d_done_busy", id), bsy, 0);
        check($sformatf("d%0d_done_vec", id), vec, 0);
        if (id == 0) e = sb0.pop_front();
        else         e = sb1.pop_front();
        check($sformatf("d%0d_table_or", id), tor, e.tor);
        check($sformatf("d%0d_table_and", id), tand, e.tand);
        check($sformatf("d%0d_mismatch", id), mm, e.mm);
        active[id] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) if (rst_n) monitor(0, 1, {ch1, a1, b1}, busy1, done1, tor1, tand1, mm1);
  always @(negedge clk) if (rst_n) monitor(1, 3, {ch3, a3, b3}, busy3, done3, tor3, tand3, mm3);

  // Record an accepted start at the edge just passed.
  task automatic accept(input int id);
    e0[id]     = cyc;
    active[id] = 1'b1;
    if (id == 0) sb0.push_back(sweep_model(mode[id]));
    else         sb1.push_back(sweep_model(mode[id]));
  endtask

  task automatic launch(input int id, input int m);
    @(posedge clk); #2;
    mode[id] = m;
    if (id == 0) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    accept(id);
    if (id == 0) start1 = 1'b0; else start3 = 1'b0;
  endtask

  task automatic wait_sweep(input int id, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!active[id]) break;
    end
    if (i == budget) begin
      check($sformatf("d%0d_timeout", id), 1, 0);
      active[id] = 1'b0;
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
    mode[0] = LU_GOOD; mode[1] = LU_GOOD;
    active[0] = 1'b0; active[1] = 1'b0;
    e0[0] = 0; e0[1] = 0;

    // Reset values.
    #3;
    check("rst_vec", {ch1, a1, b1}, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_or", tor1, 0);
    check("rst_and", tand1, 0);
    check("rst_mm", mm1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Correct model, HOLD = 1.
    launch(0, LU_GOOD);
    wait_sweep(0, 40);

    // s_or stuck at 0; mismatch stays set while idle.
    launch(0, LU_OR0);
    wait_sweep(0, 40);
    repeat (5) @(negedge clk);
    #1;
    check("sticky_mm", mm1, 1);
    check("sticky_or", tor1, 0);
    check("sticky_and", tand1, GOLD_AND);

    // s_and stuck at 1 (next start clears the stale mismatch).
    launch(0, LU_AND1);
    wait_sweep(0, 40);

    // HOLD = 3 with ignored start pulses at relative edges 5 and 20.
    launch(1, LU_GOOD);
    wait_cycle(e0[1] + 4); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    wait_cycle(e0[1] + 19); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    wait_sweep(1, 60);

    // Reset in the middle of vector 5: no done, outputs clear at once.
    launch(0, LU_GOOD);
    wait_cycle(e0[0] + 11); #2;
    rst_n = 1'b0;
    active[0] = 1'b0;
    sb0.delete();
    #1;
    check("mid_rst_vec", {ch1, a1, b1}, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_done", done1, 0);
    check("mid_rst_or", tor1, 0);
    check("mid_rst_mm", mm1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    launch(0, LU_GOOD);
    wait_sweep(0, 40);

    // start held high: back-to-back sweeps, second accept 18 edges later.
    @(posedge clk); #2;
    mode[0] = LU_GOOD;
    start1 = 1'b1;
    @(posedge clk); #1;
    accept(0);
    wait_sweep(0, 40);
    wait_cycle(e0[0] + 18);
    accept(0);
    start1 = 1'b0;
    wait_sweep(0, 40);

    repeat (3) @(posedge clk);
    check("sb0_empty", sb0.size(), 0);
    check("sb1_empty", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lu_vector_seq.md
Name: lu_vector_seq

Overview:
- Upstream stimulus sequencer and result collector for the two-function logic unit. The logic unit gives the OR result when the key is 0 and the AND result when the key is 1.
- On start, the block steps through all 8 input combinations {ch,a,b} and drives a, b and ch into the logic unit.
- It samples the unit's s_or/s_and outputs into two 4-bit truth-table registers and flags any deviation from the expected tables.
- Used as the on-chip self-check in front of the logic unit.

Parameters:
- HOLD, 1: number of cycles each vector is driven before sampling. Legal range is 1..15; 0 is illegal.
- EXP_OR, 4'b1110: expected OR truth table, indexed by {a,b}.
- EXP_AND, 4'b1000: expected AND truth table, indexed by {a,b}.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- s_or  input  1  OR-path output from the logic unit.
- s_and  input  1  AND-path output from the logic unit.
- a  output  1  operand a to the logic unit.
- b  output  1  operand b to the logic unit.
- ch  output  1  function key to the logic unit (0 = OR, 1 = AND).
- busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle.
- done  output  1  single-cycle pulse; tables and mismatch are valid in this cycle and remain valid afterwards.
- table_or  output  4  captured OR table; bit {a,b} holds s_or for that vector.
- table_and  output  4  captured AND table; bit {a,b} holds s_and for that vector.
- mismatch  output  1  sticky error flag for the current sweep.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; a, b, ch, busy, done, mismatch = 0; table_or = table_and = 4'b0000; idx = 0; hold counter = 0.
- Internal state:
  - idx[2:0] = {ch,a,b}; outputs ch/a/b are the idx bits, registered directly.
  - hold counter of 4 bits.
- IDLE: a/b/ch = 0, busy = 0.
  - If start = 1 at an edge: clear both tables and mismatch, set idx = 0, load hold = HOLD-1, go to DRIVE.
- DRIVE: busy = 1; a/b/ch stable.
  - If hold = 0, go to SAMPLE; otherwise decrement hold.
- SAMPLE (1 cycle): busy = 1; a/b/ch still stable. At the closing edge:
  - If ch = 0: table_or[{a,b}] <= s_or. If s_or != EXP_OR[{a,b}] or s_and != 0, set mismatch.
  - If ch = 1: table_and[{a,b}] <= s_and. If s_and != EXP_AND[{a,b}] or s_or != 0, set mismatch.
  - If idx = 7, go to FINISH. Otherwise idx <= idx+1, reload hold = HOLD-1, go to DRIVE.
- FINISH (1 cycle): done = 1, busy = 0, a/b/ch return to 0; then go to IDLE.
- Latency:
  - The start-accept edge is E0.
  - Vector k is driven from E0+k(HOLD+1) for HOLD+1 cycles.
  - done is high in the cycle beginning at edge E0+8(HOLD+1); with HOLD = 1 this is edge 16.
- mismatch is sticky for the sweep. It is cleared only by reset or by the next accepted start.
- table_or, table_and and mismatch hold their values in IDLE until the next accepted start.
- start while busy, or in the FINISH cycle, is ignored; no restart occurs and no state is disturbed.
- start held high continuously: a new sweep is accepted at the first IDLE edge after FINISH. The sweeps are then back to back, with one IDLE cycle between them.
- Reset mid-sweep: immediate return to the reset values, with no done pulse. A later start performs a full, clean sweep.
- Inputs s_or/s_and are sampled only at SAMPLE edges; their values in other cycles are don't-care.

Test Plan:
- Correct LU model, HOLD = 1, single start pulse -> vectors {ch,a,b} = 000..111, each stable for 2 cycles. done at edge 16. table_or = 1110, table_and = 1000, mismatch = 0; busy deasserts together with done.
- LU model with s_or stuck at 0 -> table_or = 0000, table_and = 1000, mismatch = 1 at done. mismatch stays 1 in IDLE until the next start clears it.
- LU model with s_and stuck at 1 (leaks while ch = 0) -> mismatch = 1, table_and = 1111, table_or = 1110.
- HOLD = 3, correct model -> each vector stable for 4 cycles, done at edge 32, tables 1110/1000; extra start pulses at edges 5 and 20 are ignored.
- rst_n pulsed low mid-sweep at vector 5 -> outputs go to 0 immediately, with no done. A new start then produces a full, correct sweep with done 16 cycles later.
- start held high, correct model -> two consecutive sweeps with done at edges 16 and 34. Tables are cleared at the second accept and end as 1110/1000.
